qrd_stream_ctrl: RTL and testbench
==================================

// Module: qrd_stream_ctrl
// PURPOSE
//  Sequencer that wraps the 4x4 complex QRD core.
//  - Accepts H as a 16-entry row-major complex stream and buffers it.
//  - Drives the core's skewed row_in_* inputs, including the identity columns and the _f flags, under the core's in_ready.
//  - Captures the skewed R / Q^H rows from row_out_*.
//  - Re-emits the results as one in-order valid/ready stream: R first, then QH.
// PARAMETERS
//  IN_W      14   sample width, signed two's complement, all ports
//  N         4    matrix order (fixed at 4; other values unsupported)
//  FRAC      10   fraction bits; identity diagonal is 1<<FRAC = 1024
//  WDOG_CYC  256  watchdog limit in cycles (used only with QRD_STREAM_CTRL_WDOG_EN)
// PORTS
//  clk            in   1     clock, rising edge
//  rst_n          in   1     synchronous active-low reset
//  h_valid        in   1     H sample valid
//  h_ready        out  1     H sample accepted when h_valid&&h_ready
//  h_r, h_i       in   IN_W  H[row][col], row-major order
//  row_in_k_r/_i  out  IN_W  k=1..4, to core row inputs
//  row_in_k_f     out  1     k=1..3, to core row flags
//  in_ready       in   1     core can take a step
//  out_valid      in   1     core outputs valid
//  row_out_k_r/_i in   IN_W  k=1..4, from core
//  o_valid        out  1     result sample valid
//  o_ready        in   1     downstream accept
//  o_r, o_i       out  IN_W  result sample
//  o_sel          out  1     0 = R entry, 1 = QH entry
//  o_last         out  1     high on 32nd result (QH[3][3])
//  busy           out  1     state != LOAD
//  err            out  1     sticky watchdog error (0 without the macro)
// BEHAVIOUR
//  Reset: all outputs are 0, except h_ready = 1. State = LOAD. Counters and buffers are cleared.
//    rst_n low mid-operation aborts immediately, with the same values.
//  LOAD: h_ready = 1. Count accepts 0..15 into hbuf[j][k]. The 16th accept -> FEED at step s = 0; h_ready = 0 from that cycle.
//  FEED: step counter s runs 0..15.
//    Row inputs are registered and updated on each advance to step s.
//    Extended matrix: E[j][c] = H[j][c] for c<4; E[j][c] = (c-4==j ? 1<<FRAC : 0) for c>=4. Imaginary part of identity = 0.
//    row_in_1 = s<8      ? E[0][s]   : 0
//    row_in_2 = 0<s<9    ? E[1][s-1] : 0
//    row_in_3 = 1<s<10   ? E[2][s-2] : 0
//    row_in_4 = 2<s<11   ? E[3][s-3] : 0
//    row_in_1_f = (s==0); row_in_2_f = (s==2); row_in_3_f = (s==4).
//  Advance rule:
//    s<5: advance on in_ready.
//    s>=5: advance on in_ready && out_valid. Otherwise hold; outputs and s stay unchanged.
//  Capture, on the advancing cycle of step s:
//    R[0][s-5] for s in 5..8;   QH[0][s-9]  for s in 9..12  (row_out_1)
//    R[1][s-6] for s in 6..9;   QH[1][s-10] for s in 10..13 (row_out_2)
//    R[2][s-7] for s in 7..10;  QH[2][s-11] for s in 11..14 (row_out_3)
//    R[3][s-8] for s in 8..11;  QH[3][s-12] for s in 12..15 (row_out_4)
//  Advance at s=15 -> DRAIN. Row inputs return to 0.
//  DRAIN: index d runs 0..31. o_valid = 1.
//    d<16: o = R[d/4][d%4], o_sel = 0.  d>=16: o = QH[(d-16)/4][d%4], o_sel = 1.
//    Output is held stable while o_valid && !o_ready.
//    Transfer at d = 31 (o_last = 1) -> LOAD. h_ready = 1 the next cycle.
//  No overlap: a new H is not accepted until DRAIN completes. h_valid in FEED/DRAIN is ignored.
//  No arithmetic on samples; widths pass through unchanged. Identity constant is truncated to IN_W (requires FRAC <= IN_W-2).
// CONFIGURATION
//  QRD_STREAM_CTRL_WDOG_EN defined:
//    Counter resets on every FEED advance and on every DRAIN transfer.
//    It counts stalled cycles in FEED/DRAIN. On reaching WDOG_CYC: err <= 1 (sticky until reset), state -> LOAD, row inputs -> 0, o_valid -> 0.
//  Not defined: err is tied to 0; stalls wait forever.
// STRUCTURE
//  qrd_pkg: IN_W, N, FRAC, state enum {LOAD, FEED, DRAIN},
//    step constants R_START = 5, QH_START = 9, LAST_STEP = 15.
//  Sub-module qrd_out_collector: capture table plus 32-entry result buffer and DRAIN read mux.
//    The top level holds the FSM, hbuf, and the skewed feed mux.
// TESTING
//  1. Load H with H[j][k] = 16*j+k, real only, in_ready = 1.
//     -> row_in_1 at s = 4..7 = 1024, 0, 0, 0; row_in_4 at s = 3 = 48.
//     -> flags high exactly at s = 0 / 2 / 4.
//  2. Core model returns R[j][k] = 100*j+k, QH = 200+.
//     -> o stream: 0, 1, 2, 3, 100, ..., 303, then 200, ... with o_sel 0x16 then 1x16; o_last only on the 32nd.
//  3. Drop in_ready for 3 cycles at s = 6 -> s and row_in_* hold 3 cycles; captured R is unchanged vs. test 2.
//  4. o_ready toggled 1,0,0,1 in DRAIN -> each sample is held while stalled; no loss or duplication; 32 transfers.
//  5. rst_n low for 1 cycle at s = 9 -> next cycle h_ready = 1, o_valid = 0, row_in_* = 0.
//     -> A fresh load reproduces test 2 exactly.
//  6. (WDOG_EN, WDOG_CYC = 8) hold out_valid = 0 at s = 5 -> err = 1 after 8 cycles, state = LOAD, err stays 1.

Source files
------------

// File: rtl/qrd_pkg.sv
// Shared constants for the 4x4 complex QRD stream sequencer.
//   IN_W      sample width (signed two's complement) on every sample port
//   N         matrix order, fixed at 4
//   FRAC      fraction bits; the identity diagonal is 1<<FRAC
//   LOAD/FEED/DRAIN   sequencer states
//   R_START/QH_START/LAST_STEP   feed-step landmarks of the core schedule
package qrd_pkg;
  localparam int IN_W = 14;
  localparam int N    = 4;
  localparam int FRAC = 10;

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] FEED  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam int R_START   = 5;
  localparam int QH_START  = 9;
  localparam int LAST_STEP = 15;

  localparam logic [IN_W-1:0] ID_ONE = IN_W'(1 << FRAC);
endpackage

// File: rtl/qrd_out_collector.sv
// Captures the skewed R / Q^H rows coming back from the QRD core and serves
// them as a flat 32-entry buffer: entries 0..15 are R row-major, 16..31 are
// Q^H row-major.
//   clk, rst_n        clock, synchronous active-low clear of the buffer
//   cap_en            the feed step advances this cycle
//   step              current feed step s (0..15)
//   row_r, row_i      core row outputs, index 0 = row_out_1
//   rd_idx            drain index d
//   rd_r, rd_i        buffer entry at rd_idx
module qrd_out_collector
  import qrd_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cap_en,
  input  logic [3:0]             step,
  input  logic [N-1:0][IN_W-1:0] row_r,
  input  logic [N-1:0][IN_W-1:0] row_i,
  input  logic [4:0]             rd_idx,
  output logic [IN_W-1:0]        rd_r,
  output logic [IN_W-1:0]        rd_i
);
  logic [2*N*N-1:0][IN_W-1:0] res_r, res_i;
  logic [N-1:0]               wr_en;
  logic [N-1:0][4:0]          wr_idx;

  // Row j emits R[j][0..3] then QH[j][0..3] on steps R_START+j .. R_START+j+7,
  // so each row writes a distinct entry and rows never collide.
  always_comb begin
    int c;
    wr_en  = '0;
    wr_idx = '0;
    c      = 0;
    for (int j = 0; j < N; j++) begin
      c = int'(step) - R_START - j;
      if (cap_en && c >= 0 && c < 2*N) begin
        wr_en[j]  = 1'b1;
        wr_idx[j] = (c < QH_START - R_START) ? 5'(j*N + c)
                                             : 5'(N*N + j*N + c - N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_r <= '0;
      res_i <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (wr_en[j]) begin
          res_r[wr_idx[j]] <= row_r[j];
          res_i[wr_idx[j]] <= row_i[j];
        end
      end
    end
  end

  assign rd_r = res_r[rd_idx];
  assign rd_i = res_i[rd_idx];
endmodule

// File: rtl/qrd_stream_ctrl.sv
// Sequencer around the 4x4 complex QRD core: buffers a row-major H stream,
// feeds the core's skewed row inputs (H plus identity columns, with the
// row flags), collects the skewed R / Q^H outputs and replays them as one
// valid/ready stream, R first then Q^H.
// Optional feature: define QRD_STREAM_CTRL_WDOG_EN for a stall watchdog
// (WDOG_CYC cycles) that raises sticky err and returns to LOAD.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   h_valid/h_ready/h_r/h_i     H sample input stream
//   row_in_k_r/_i, row_in_k_f   core row inputs and flags
//   in_ready, out_valid         core step handshakes
//   row_out_k_r/_i              core row outputs
//   o_valid/o_ready/o_r/o_i     result stream, o_sel = 0 R / 1 QH,
//   o_sel, o_last               o_last on the 32nd sample
//   busy, err                   not-in-LOAD, sticky watchdog error
module qrd_stream_ctrl
  import qrd_pkg::*;
#(
  parameter int WDOG_CYC = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            h_valid,
  output logic            h_ready,
  input  logic [IN_W-1:0] h_r,
  input  logic [IN_W-1:0] h_i,
  output logic [IN_W-1:0] row_in_1_r,
  output logic [IN_W-1:0] row_in_1_i,
  output logic [IN_W-1:0] row_in_2_r,
  output logic [IN_W-1:0] row_in_2_i,
  output logic [IN_W-1:0] row_in_3_r,
  output logic [IN_W-1:0] row_in_3_i,
  output logic [IN_W-1:0] row_in_4_r,
  output logic [IN_W-1:0] row_in_4_i,
  output logic            row_in_1_f,
  output logic            row_in_2_f,
  output logic            row_in_3_f,
  input  logic            in_ready,
  input  logic            out_valid,
  input  logic [IN_W-1:0] row_out_1_r,
  input  logic [IN_W-1:0] row_out_1_i,
  input  logic [IN_W-1:0] row_out_2_r,
  input  logic [IN_W-1:0] row_out_2_i,
  input  logic [IN_W-1:0] row_out_3_r,
  input  logic [IN_W-1:0] row_out_3_i,
  input  logic [IN_W-1:0] row_out_4_r,
  input  logic [IN_W-1:0] row_out_4_i,
  output logic            o_valid,
  input  logic            o_ready,
  output logic [IN_W-1:0] o_r,
  output logic [IN_W-1:0] o_i,
  output logic            o_sel,
  output logic            o_last,
  output logic            busy,
  output logic            err
);
  if (WDOG_CYC < 2 || FRAC > IN_W - 2 || N != 4) begin : g_cfg_check
    $error("qrd_stream_ctrl: unsupported parameter combination");
  end

  logic [1:0]                 state;
  logic [3:0]                 load_cnt, s;
  logic [4:0]                 d;
  logic [N*N-1:0][IN_W-1:0]   hbuf_r, hbuf_i;
  logic [N-1:0][IN_W-1:0]     rin_r, rin_i, nxt_r, nxt_i, rout_r, rout_i;
  logic [2:0]                 rin_f, nxt_f;
  logic                       h_acc, load_done, feed_adv, feed_done, xfer;
  logic                       wdog_trip;
  logic [IN_W-1:0]            rd_r, rd_i;

  assign h_acc     = (state == LOAD) && h_valid;
  assign load_done = h_acc && (load_cnt == 4'd15);
  // Before R_START the core output is not yet meaningful, so only in_ready gates.
  assign feed_adv  = (state == FEED) && in_ready && ((int'(s) < R_START) || out_valid);
  assign feed_done = feed_adv && (int'(s) == LAST_STEP);
  assign xfer      = (state == DRAIN) && o_ready;

  // Row inputs for the step being entered: step 0 from LOAD, s+1 from FEED.
  // Row j carries extended column t-j of [H | I].
  always_comb begin
    int t, c;
    logic [3:0] hidx;
    t     = (state == LOAD) ? 0 : int'(s) + 1;
    c     = 0;
    hidx  = '0;
    nxt_r = '0;
    nxt_i = '0;
    for (int j = 0; j < N; j++) begin
      c = t - j;
      if (c >= 0 && c < N) begin
        hidx     = 4'(j*N + c);
        nxt_r[j] = hbuf_r[hidx];
        nxt_i[j] = hbuf_i[hidx];
      end else if (c - N == j) begin
        nxt_r[j] = ID_ONE;
      end
    end
    nxt_f = {t == 4, t == 2, t == 0};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= LOAD;
      load_cnt <= '0;
      s        <= '0;
      d        <= '0;
      hbuf_r   <= '0;
      hbuf_i   <= '0;
      rin_r    <= '0;
      rin_i    <= '0;
      rin_f    <= '0;
    end else if (wdog_trip) begin
      state    <= LOAD;
      load_cnt <= '0;
      s        <= '0;
      d        <= '0;
      rin_r    <= '0;
      rin_i    <= '0;
      rin_f    <= '0;
    end else begin
      case (state)
        LOAD: if (h_acc) begin
          hbuf_r[load_cnt] <= h_r;
          hbuf_i[load_cnt] <= h_i;
          load_cnt         <= load_cnt + 4'd1;  // wraps to 0 on the 16th accept
          if (load_done) begin
            state <= FEED;
            s     <= '0;
            rin_r <= nxt_r;
            rin_i <= nxt_i;
            rin_f <= nxt_f;
          end
        end
        FEED: if (feed_adv) begin
          if (feed_done) begin
            state <= DRAIN;
            d     <= '0;
            rin_r <= '0;
            rin_i <= '0;
            rin_f <= '0;
          end else begin
            s     <= s + 4'd1;
            rin_r <= nxt_r;
            rin_i <= nxt_i;
            rin_f <= nxt_f;
          end
        end
        DRAIN: if (xfer) begin
          d <= d + 5'd1;
          if (d == 5'd31) state <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef QRD_STREAM_CTRL_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC);
  logic [WW-1:0] wcnt;
  logic          stall, err_q;

  assign stall     = ((state == FEED) && !feed_adv) || ((state == DRAIN) && !xfer);
  assign wdog_trip = stall && (wcnt == WW'(WDOG_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (wdog_trip) err_q <= 1'b1;
      if (stall && !wdog_trip) wcnt <= wcnt + 1'b1;
      else                     wcnt <= '0;
    end
  end
  assign err = err_q;
`else
  assign wdog_trip = 1'b0;
  assign err       = 1'b0;
`endif

  assign rout_r = {row_out_4_r, row_out_3_r, row_out_2_r, row_out_1_r};
  assign rout_i = {row_out_4_i, row_out_3_i, row_out_2_i, row_out_1_i};

  qrd_out_collector u_coll (
    .clk    (clk),
    .rst_n  (rst_n),
    .cap_en (feed_adv),
    .step   (s),
    .row_r  (rout_r),
    .row_i  (rout_i),
    .rd_idx (d),
    .rd_r   (rd_r),
    .rd_i   (rd_i)
  );

  assign h_ready    = (state == LOAD);
  assign busy       = (state != LOAD);
  assign o_valid    = (state == DRAIN);
  assign o_r        = o_valid ? rd_r : '0;
  assign o_i        = o_valid ? rd_i : '0;
  assign o_sel      = o_valid && d[4];
  assign o_last     = o_valid && (d == 5'd31);

  assign row_in_1_r = rin_r[0];
  assign row_in_1_i = rin_i[0];
  assign row_in_2_r = rin_r[1];
  assign row_in_2_i = rin_i[1];
  assign row_in_3_r = rin_r[2];
  assign row_in_3_i = rin_i[2];
  assign row_in_4_r = rin_r[3];
  assign row_in_4_i = rin_i[3];
  assign row_in_1_f = rin_f[0];
  assign row_in_2_f = rin_f[1];
  assign row_in_3_f = rin_f[2];
endmodule

// File: tb/tb_qrd_stream_ctrl.sv
// Bench for qrd_stream_ctrl: directed scenarios (skewed feed contents, R/QH
// replay, feed stall, drain backpressure, mid-run reset) plus randomized runs
// against a matrix-level reference of the feed and result streams.
module tb_qrd_stream_ctrl;
  typedef logic [13:0] smp_t;
  typedef struct { int s; int row; int exp_r; logic [2:0] exp_f; } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic h_valid = 1'b0, in_ready = 1'b0, out_valid = 1'b0, o_ready = 1'b0;
  smp_t h_r = '0, h_i = '0;
  logic h_ready, o_valid, o_sel, o_last, busy, err;
  logic row_in_1_f, row_in_2_f, row_in_3_f;
  smp_t o_r, o_i;
  smp_t row_in_1_r, row_in_1_i, row_in_2_r, row_in_2_i;
  smp_t row_in_3_r, row_in_3_i, row_in_4_r, row_in_4_i;
  smp_t ro_r[4], ro_i[4];
  wire [13:0] ri_r[4], ri_i[4];

  assign ri_r[0] = row_in_1_r;  assign ri_i[0] = row_in_1_i;
  assign ri_r[1] = row_in_2_r;  assign ri_i[1] = row_in_2_i;
  assign ri_r[2] = row_in_3_r;  assign ri_i[2] = row_in_3_i;
  assign ri_r[3] = row_in_4_r;  assign ri_i[3] = row_in_4_i;

  qrd_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .h_valid(h_valid), .h_ready(h_ready), .h_r(h_r), .h_i(h_i),
    .row_in_1_r(row_in_1_r), .row_in_1_i(row_in_1_i), .row_in_2_r(row_in_2_r), .row_in_2_i(row_in_2_i),
    .row_in_3_r(row_in_3_r), .row_in_3_i(row_in_3_i), .row_in_4_r(row_in_4_r), .row_in_4_i(row_in_4_i),
    .row_in_1_f(row_in_1_f), .row_in_2_f(row_in_2_f), .row_in_3_f(row_in_3_f),
    .in_ready(in_ready), .out_valid(out_valid),
    .row_out_1_r(ro_r[0]), .row_out_1_i(ro_i[0]), .row_out_2_r(ro_r[1]), .row_out_2_i(ro_i[1]),
    .row_out_3_r(ro_r[2]), .row_out_3_i(ro_i[2]), .row_out_4_r(ro_r[3]), .row_out_4_i(ro_i[3]),
    .o_valid(o_valid), .o_ready(o_ready), .o_r(o_r), .o_i(o_i), .o_sel(o_sel), .o_last(o_last),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference matrices: H in, R and QH as the core would produce them.
  smp_t hm_r[4][4], hm_i[4][4], rm_r[4][4], rm_i[4][4], qm_r[4][4], qm_i[4][4];
  smp_t obs_r[16][4];
  logic [2:0] obs_f[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Extended matrix [H | I] entry E[j][c].
  function automatic smp_t ext(input int j, input int c, input bit im);
    if (c < 4) return im ? hm_i[j][c] : hm_r[j][c];
    return (!im && (c - 4 == j)) ? smp_t'(1024) : smp_t'(0);
  endfunction

  // Row j enters the core j steps late and spans 8 columns.
  function automatic smp_t exp_in(input int j, input int s, input bit im);
    if (s < j || s > j + 7) return '0;
    return ext(j, s - j, im);
  endfunction

  // Core model: row j returns R[j][*] then QH[j][*] starting at step 5+j.
  function automatic smp_t core_out(input int j, input int s, input bit im);
    int c;
    c = s - 5 - j;
    if (c < 0 || c > 7) return smp_t'($urandom);
    if (c < 4) return im ? rm_i[j][c] : rm_r[j][c];
    return im ? qm_i[j][c-4] : qm_r[j][c-4];
  endfunction

  function automatic smp_t exp_o(input int d, input bit im);
    if (d < 16) return im ? rm_i[d/4][d%4] : rm_r[d/4][d%4];
    return im ? qm_i[(d-16)/4][d%4] : qm_r[(d-16)/4][d%4];
  endfunction

  task automatic set_directed();
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) begin
        hm_r[j][k] = smp_t'(16*j + k);  hm_i[j][k] = '0;
        rm_r[j][k] = smp_t'(100*j + k); rm_i[j][k] = smp_t'(50 + 4*j + k);
        qm_r[j][k] = smp_t'(200 + 10*j + k); qm_i[j][k] = smp_t'(500 + 10*j + k);
      end
  endtask

  task automatic set_random();
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) begin
        hm_r[j][k] = smp_t'($urandom); hm_i[j][k] = smp_t'($urandom);
        rm_r[j][k] = smp_t'($urandom); rm_i[j][k] = smp_t'($urandom);
        qm_r[j][k] = smp_t'($urandom); qm_i[j][k] = smp_t'($urandom);
      end
  endtask

  task automatic load_h(input bit gaps);
    int idx, guard;
    idx = 0; guard = 0;
    while (idx < 16 && guard < 500) begin
      guard++;
      h_valid = gaps ? (($urandom % 3) != 0) : 1'b1;
      h_r = hm_r[idx/4][idx%4];
      h_i = hm_i[idx/4][idx%4];
      @(negedge clk);
      chk("load_h_ready", h_ready, 1);
      chk("load_busy", busy, 0);
      chk("load_o_valid", o_valid, 0);
      @(posedge clk); #1;
      if (h_valid) idx++;
    end
    h_valid = 1'b0;
    if (idx < 16) chk("load_timeout", idx, 16);
  endtask

  // mode 0: no stalls, 1: in_ready low 3 cycles at s=6, 2: random stalls.
  task automatic run_feed(input int mode, input int abort_at, output bit aborted);
    int s, guard, st;
    bit ir, ov, adv;
    s = 0; guard = 0; st = 0; aborted = 1'b0;
    while (s < 16 && guard < 2000) begin
      guard++;
      if (s == abort_at) begin
        in_ready = 1'b0; out_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_h_ready", h_ready, 1);
        chk("abort_o_valid", o_valid, 0);
        chk("abort_busy", busy, 0);
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("abort_row%0d_r", j+1), ri_r[j], 0);
          chk($sformatf("abort_row%0d_i", j+1), ri_i[j], 0);
        end
        chk("abort_flags", {row_in_3_f, row_in_2_f, row_in_1_f}, 0);
        @(posedge clk); #1;
        aborted = 1'b1;
        return;
      end
      case (mode)
        0: begin ir = 1'b1; ov = (s >= 5); end
        1: begin
          if (s == 6 && st < 3) begin ir = 1'b0; st++; end
          else ir = 1'b1;
          ov = (s >= 5);
        end
        default: begin ir = ($urandom % 4) != 0; ov = ($urandom % 3) != 0; end
      endcase
      adv = ir && (s < 5 || ov);
      in_ready = ir; out_valid = ov;
      h_valid = $urandom % 2; h_r = smp_t'($urandom);
      for (int j = 0; j < 4; j++) begin
        ro_r[j] = adv ? core_out(j, s, 1'b0) : smp_t'($urandom);
        ro_i[j] = adv ? core_out(j, s, 1'b1) : smp_t'($urandom);
      end
      @(negedge clk);
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("feed_s%0d_row%0d_r", s, j+1), ri_r[j], exp_in(j, s, 1'b0));
        chk($sformatf("feed_s%0d_row%0d_i", s, j+1), ri_i[j], exp_in(j, s, 1'b1));
        obs_r[s][j] = ri_r[j];
      end
      obs_f[s] = {row_in_3_f, row_in_2_f, row_in_1_f};
      chk($sformatf("feed_s%0d_flags", s), obs_f[s], {s == 4, s == 2, s == 0});
      chk("feed_h_ready", h_ready, 0);
      chk("feed_busy", busy, 1);
      chk("feed_o_valid", o_valid, 0);
      @(posedge clk); #1;
      if (adv) s++;
    end
    in_ready = 1'b0; out_valid = 1'b0; h_valid = 1'b0;
    if (s < 16) chk("feed_timeout", s, 16);
  endtask

  // mode 0: o_ready high, 1: pattern 1,0,0,1, 2: random.
  task automatic run_drain(input int mode);
    int d, guard, ph;
    bit rdy;
    d = 0; guard = 0; ph = 0;
    while (d < 32 && guard < 1000) begin
      guard++;
      case (mode)
        0: rdy = 1'b1;
        1: begin rdy = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
        default: rdy = $urandom % 2;
      endcase
      o_ready = rdy;
      h_valid = $urandom % 2; in_ready = $urandom % 2; out_valid = $urandom % 2;
      @(negedge clk);
      chk("drain_o_valid", o_valid, 1);
      chk($sformatf("drain_d%0d_o_r", d), o_r, exp_o(d, 1'b0));
      chk($sformatf("drain_d%0d_o_i", d), o_i, exp_o(d, 1'b1));
      chk($sformatf("drain_d%0d_o_sel", d), o_sel, d >= 16);
      chk($sformatf("drain_d%0d_o_last", d), o_last, d == 31);
      chk("drain_h_ready", h_ready, 0);
      chk("drain_row_in_1", row_in_1_r, 0);
      @(posedge clk); #1;
      if (rdy) d++;
    end
    o_ready = 1'b0; h_valid = 1'b0; in_ready = 1'b0; out_valid = 1'b0;
    if (d < 32) chk("drain_timeout", d, 32);
    @(negedge clk);
    chk("post_drain_o_valid", o_valid, 0);
    chk("post_drain_h_ready", h_ready, 1);
    chk("post_drain_busy", busy, 0);
    chk("post_drain_err", err, 0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[14];
  bit ab;

  initial begin
    tbl[0]  = '{0, 1, 0, 3'b001};     tbl[1]  = '{1, 2, 16, 3'b000};
    tbl[2]  = '{2, 3, 32, 3'b010};    tbl[3]  = '{3, 4, 48, 3'b000};
    tbl[4]  = '{4, 1, 1024, 3'b100};  tbl[5]  = '{5, 1, 0, 3'b000};
    tbl[6]  = '{6, 1, 0, 3'b000};     tbl[7]  = '{7, 1, 0, 3'b000};
    tbl[8]  = '{6, 2, 1024, 3'b000};  tbl[9]  = '{8, 3, 1024, 3'b000};
    tbl[10] = '{10, 4, 1024, 3'b000}; tbl[11] = '{6, 4, 51, 3'b000};
    tbl[12] = '{11, 4, 0, 3'b000};    tbl[13] = '{15, 1, 0, 3'b000};
    for (int j = 0; j < 4; j++) begin ro_r[j] = '0; ro_i[j] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_h_ready", h_ready, 1);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_o_r", o_r, 0);
    chk("rst_o_last", o_last, 0);
    chk("rst_row_in_4_r", row_in_4_r, 0);
    chk("rst_flags", {row_in_3_f, row_in_2_f, row_in_1_f}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed load, feed contents, in-order replay
    set_directed();
    load_h(1'b0);
    run_feed(0, -1, ab);
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d_row%0d_s%0d", i, tbl[i].row, tbl[i].s),
          obs_r[tbl[i].s][tbl[i].row-1], tbl[i].exp_r);
      chk($sformatf("tbl%0d_flags_s%0d", i, tbl[i].s), obs_f[tbl[i].s], tbl[i].exp_f);
    end
    run_drain(0);

    // in_ready dropped 3 cycles at s=6
    load_h(1'b0);
    run_feed(1, -1, ab);
    run_drain(0);

    // Drain backpressure 1,0,0,1
    load_h(1'b0);
    run_feed(0, -1, ab);
    run_drain(1);

    // Reset at s=9, then a fresh run
    load_h(1'b0);
    run_feed(0, 9, ab);
    chk("abort_taken", ab, 1);
    load_h(1'b0);
    run_feed(0, -1, ab);
    run_drain(0);

    // Randomized runs
    for (int it = 0; it < 6; it++) begin
      set_random();
      load_h(1'b1);
      run_feed(2, -1, ab);
      run_drain(2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end
endmodule
